jtcontra_romrq: RTL and testbench
=================================

Name: jtcontra_romrq

Overview:
- One SDRAM read slot for the game's ROM paths: main CPU, sound CPU, ADPCM, GFX1 and GFX2 tile/object fetch.
- Upstream side: a requester's byte/word address and chip select.
- Downstream side: one request toward the SDRAM controller, using the same req/ack/data_rdy handshake the game top exposes.
- Keeps a two-entry word cache so sequential CPU fetches and repeated tile reads hit locally, and reports data_ok when dout matches the current address.

Parameters:
AW, 18, requester address width
DW, 8, requester data width; 8 (byte-addressed) or 16 (word-addressed)
OFFSET, 22'h0, SDRAM word offset added to the slot address
REPL_RR, 1, 1 = round-robin replacement; 0 = always replace entry 0

Ports:
clk  in  1  system clock; every register samples on rising edge
rst  in  1  asynchronous, active-low reset
downloading  in  1  ROM download in progress; flushes the cache
addr  in  AW  requester address
cs  in  1  requester chip select
dout  out  DW  read data
data_ok  out  1  dout is valid for addr
sdram_req  out  1  request to the SDRAM controller
sdram_addr  out  22  SDRAM word address
sdram_ack  in  1  controller accepted the request (1-cycle pulse)
data_rdy  in  1  data_read valid for this slot (1-cycle pulse)
data_read  in  16  SDRAM read data

Behaviour:
- Reset (rst=0, asynchronous): dout=0, data_ok=0, sdram_req=0, sdram_addr=0, both entries invalid, replacement pointer=0, state=IDLE.
- Word address:
  - DW=16: waddr = addr.
  - DW=8: waddr = addr[AW-1:1]; byte select = addr[0] (0 = data[7:0], 1 = data[15:8]).
- sdram_addr = OFFSET + zero-extended waddr. Width is 22 bits; overflow wraps modulo 2^22.
- Cache: 2 entries of {valid, tag = waddr, data[15:0]}.
- Hit at cycle t: cs=1 and a valid entry's tag equals waddr. Then at t+1, data_ok=1 and dout holds the selected word/byte. Latency is one cycle and registered.
- data_ok at t+1 is 0 if at cycle t: cs=0, or a miss, or addr differs from the address of the pending result. An address change therefore drops data_ok the following cycle.
- FSM states:
  - IDLE: cs=1 with a miss -> REQ. sdram_addr is latched and sdram_req=1 on entry.
  - REQ: sdram_req held high until sdram_ack; ack -> WAIT with sdram_req=0 in the same edge.
  - WAIT: on data_rdy, data_read is written to the entry at the replacement pointer (valid=1, tag = latched waddr); the pointer toggles if REPL_RR; -> IDLE.
- Fill cycle: if addr still equals the latched waddr, data_ok=1 on the next cycle (the fill counts as a hit; no extra cycle).
- Address changes or cs drops during REQ/WAIT: the transfer completes and fills the cache (no cancellation). A new miss is serviced from IDLE afterwards.
- Both entries miss on the same waddr: only one request is issued. Duplicate tags are never created; a fill over a matching tag overwrites that entry.
- downloading=1: both valid bits clear every cycle, sdram_req forced to 0, state -> IDLE, data_ok=0. The slot stays silent until downloading=0.
- sdram_ack in IDLE or WAIT and data_rdy in IDLE or REQ are ignored.
- Back-to-back: a miss arriving in the same cycle the FSM returns to IDLE issues its request the next cycle (one idle cycle minimum between requests).

Decomposition:
- Package jtcontra_rom_pkg holds:
  - SDRAM_AW=22
  - state encoding IDLE/REQ/WAIT (2 bits)
  - byte-select helper function
- Sub-module jtcontra_romrq_tags: two-entry tag/data store with hit compare, hit index, fill port and flush. The FSM and handshake stay in jtcontra_romrq.

Test Plan:
- Cold miss: DW=8, OFFSET=22'h1_0000, addr=18'h00003, cs=1.
  - sdram_req=1 with sdram_addr=22'h1_0001.
  - ack at +3 -> req=0.
  - data_rdy with data_read=16'hA55A -> data_ok=1 the next cycle, dout=8'hA5.
- Hit: after the cold miss, addr=18'h00002 -> data_ok=1 one cycle later, dout=8'h5A, no sdram_req.
- Replacement: REPL_RR=1; fill waddr 1, 2, then 3 -> waddr 1 evicted; re-read of 2 hits; re-read of 1 issues sdram_req.
- Address change mid-WAIT: request waddr 5, switch addr to waddr 9 before data_rdy.
  - Fill of 5 completes with data_ok=0.
  - A second request for 9 follows.
  - A later read of 5 hits.
- Flush: cache holding waddr 1 and 2, pulse downloading for 4 cycles while in REQ.
  - sdram_req drops the same cycle.
  - After release, reading waddr 1 misses and re-requests.
- Async reset: assert rst=0 mid-WAIT without a clock edge -> outputs go to reset values immediately; a stray data_rdy after release is ignored.

Source files
------------

// File: rtl/jtcontra_rom_pkg.sv
// Shared constants and helpers for the Contra SDRAM ROM read slot.
package jtcontra_rom_pkg;

    localparam int SDRAM_AW = 22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Byte lane of a 16-bit SDRAM word: hi=0 -> [7:0], hi=1 -> [15:8]
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jtcontra_romrq_tags.sv
// Two-entry tag/data store: combinational hit lookup, single fill port, flush.
module jtcontra_romrq_tags #(
    parameter int TW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [TW-1:0] lookup,
    output logic          hit,
    output logic [15:0]   hit_data,
    input  logic          fill,
    input  logic [TW-1:0] fill_tag,
    input  logic [15:0]   fill_data,
    input  logic          fill_idx
);
    logic          valid [2];
    logic [TW-1:0] tag   [2];
    logic [15:0]   data  [2];
    logic [1:0]    match;
    logic [1:0]    fill_match;
    logic          wr_idx;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
            assign match[gi]      = valid[gi] && (tag[gi] == lookup);
            assign fill_match[gi] = valid[gi] && (tag[gi] == fill_tag);
        end
    endgenerate

    assign hit      = |match;
    assign hit_data = match[0] ? data[0] : data[1];
    // A fill over an already-present tag reuses that entry so tags stay unique
    assign wr_idx   = fill_match[0] ? 1'b0 : (fill_match[1] ? 1'b1 : fill_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                valid[i] <= 1'b0;
                tag[i]   <= '0;
                data[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < 2; i++) valid[i] <= 1'b0;
        end else if (fill) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_idx == 1'(i)) begin
                    valid[i] <= 1'b1;
                    tag[i]   <= fill_tag;
                    data[i]  <= fill_data;
                end
            end
        end
    end

endmodule

// File: rtl/jtcontra_romrq.sv
// SDRAM read slot with a two-entry word cache and req/ack/data_rdy handshake.
module jtcontra_romrq
    import jtcontra_rom_pkg::*;
#(
    parameter int          AW      = 18,
    parameter int          DW      = 8,
    parameter logic [21:0] OFFSET  = 22'h0,
    parameter bit          REPL_RR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [AW-1:0]       addr,
    input  logic                cs,
    output logic [DW-1:0]       dout,
    output logic                data_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);
    localparam int TW = (DW == 16) ? AW : AW - 1;

    logic [TW-1:0]       waddr;
    logic [TW-1:0]       req_tag;
    logic [SDRAM_AW-1:0] waddr_ext;
    logic [1:0]          state;
    logic                ptr;
    logic                hit;
    logic [15:0]         hit_data;
    logic [DW-1:0]       hit_fmt;
    logic [DW-1:0]       fill_fmt;
    logic                fill;
    logic                fill_match;
    logic                ok_next;

    generate
        if (DW == 16) begin : g_word
            assign waddr    = addr;
            assign hit_fmt  = hit_data;
            assign fill_fmt = data_read;
        end else begin : g_byte
            assign waddr    = addr[AW-1:1];
            assign hit_fmt  = byte_sel(hit_data, addr[0]);
            assign fill_fmt = byte_sel(data_read, addr[0]);
        end
    endgenerate

    assign waddr_ext  = SDRAM_AW'(waddr);
    assign fill       = (state == ST_WAIT) && data_rdy && !downloading;
    // The arriving word answers the current request only if addr still points at it
    assign fill_match = fill && cs && (waddr == req_tag);
    assign ok_next    = fill_match || (cs && hit);

    jtcontra_romrq_tags #(.TW(TW)) u_tags (
        .clk       (clk),
        .rst       (rst),
        .flush     (downloading),
        .lookup    (waddr),
        .hit       (hit),
        .hit_data  (hit_data),
        .fill      (fill),
        .fill_tag  (req_tag),
        .fill_data (data_read),
        .fill_idx  (ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            req_tag    <= '0;
            dout       <= '0;
            data_ok    <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else if (downloading) begin
            state     <= ST_IDLE;
            sdram_req <= 1'b0;
            data_ok   <= 1'b0;
        end else begin
            data_ok <= ok_next;
            if (ok_next) dout <= fill_match ? fill_fmt : hit_fmt;
            case (state)
                ST_IDLE: begin
                    if (cs && !hit) begin
                        state      <= ST_REQ;
                        sdram_req  <= 1'b1;
                        sdram_addr <= OFFSET + waddr_ext;
                        req_tag    <= waddr;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        state     <= ST_WAIT;
                        sdram_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        state <= ST_IDLE;
                        if (REPL_RR) ptr <= ~ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcontra_romrq.sv
// Directed bench for jtcontra_romrq (DW=8, OFFSET=22'h1_0000, round-robin).
module tb_jtcontra_romrq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        downloading = 1'b0;
    logic [17:0] addr = '0;
    logic        cs = 1'b0;
    logic [7:0]  dout;
    logic        data_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [15:0] data_read = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtcontra_romrq #(.AW(18), .DW(8), .OFFSET(22'h1_0000), .REPL_RR(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .addr        (addr),
        .cs          (cs),
        .dout        (dout),
        .data_ok     (data_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; cs = 1'b0; addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait for a request; reports whether one was seen and its address
    task automatic wait_req(output logic seen, output logic [21:0] a);
        seen = 1'b0; a = '0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (sdram_req) begin seen = 1'b1; a = sdram_addr; end
        end
    endtask

    // Acknowledge the pending request, then deliver one data word
    task automatic serve(input logic [15:0] d);
        sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
        data_rdy = 1'b1; data_read = d; @(negedge clk); data_rdy = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [17:0] a, input logic [15:0] d,
                         input logic [21:0] exp_sa, input logic [7:0] exp_b);
        logic seen; logic [21:0] sa;
        addr = a; cs = 1'b1;
        wait_req(seen, sa);
        check({tag, " req"}, 32'(seen), 32'd1);
        check({tag, " sdram_addr"}, 32'(sa), 32'(exp_sa));
        serve(d);
        check({tag, " fill ok"}, 32'(data_ok), 32'd1);
        check({tag, " fill dout"}, 32'(dout), 32'(exp_b));
    endtask

    task automatic expect_hit(input string tag, input logic [17:0] a, input logic [7:0] exp_b);
        addr = a; cs = 1'b1;
        @(negedge clk);
        check({tag, " ok"}, 32'(data_ok), 32'd1);
        check({tag, " dout"}, 32'(dout), 32'(exp_b));
        check({tag, " no req"}, 32'(sdram_req), 32'd0);
    endtask

    initial begin
        logic seen; logic [21:0] sa;

        // Reset values
        do_reset();
        check("reset dout", 32'(dout), 32'd0);
        check("reset data_ok", 32'(data_ok), 32'd0);
        check("reset req", 32'(sdram_req), 32'd0);
        check("reset sdram_addr", 32'(sdram_addr), 32'd0);

        // Cold miss: addr 3 -> waddr 1, ack three cycles after req
        addr = 18'h00003; cs = 1'b1;
        @(negedge clk);
        check("cold req", 32'(sdram_req), 32'd1);
        check("cold sdram_addr", 32'(sdram_addr), 32'h1_0001);
        check("cold ok low", 32'(data_ok), 32'd0);
        repeat (2) @(negedge clk);
        check("cold req held", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
        check("cold req dropped", 32'(sdram_req), 32'd0);
        data_rdy = 1'b1; data_read = 16'hA55A; @(negedge clk); data_rdy = 1'b0;
        check("cold fill ok", 32'(data_ok), 32'd1);
        check("cold fill dout", 32'(dout), 32'hA5);

        // Hit on the other byte of the same word, then cs drop
        expect_hit("hit addr2", 18'h00002, 8'h5A);
        cs = 1'b0; @(negedge clk);
        check("cs low ok", 32'(data_ok), 32'd0);

        // Replacement: waddr 1 (already cached in entry 0), fill 2 then 3 evicts 1
        fetch("fill w2", 18'h00004, 16'h2222, 22'h1_0002, 8'h22);
        fetch("fill w3", 18'h00006, 16'h3333, 22'h1_0003, 8'h33);
        expect_hit("reread w2", 18'h00005, 8'h22);
        fetch("refetch w1", 18'h00002, 16'h1111, 22'h1_0001, 8'h11);

        // Address change during WAIT
        do_reset();
        addr = 18'h0000A; cs = 1'b1;
        wait_req(seen, sa);
        check("w5 req", 32'(seen), 32'd1);
        check("w5 sdram_addr", 32'(sa), 32'h1_0005);
        sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
        addr = 18'h00012;
        data_rdy = 1'b1; data_read = 16'h5555; @(negedge clk); data_rdy = 1'b0;
        check("w5 fill ok low", 32'(data_ok), 32'd0);
        wait_req(seen, sa);
        check("w9 req", 32'(seen), 32'd1);
        check("w9 sdram_addr", 32'(sa), 32'h1_0009);
        serve(16'h9999);
        check("w9 fill ok", 32'(data_ok), 32'd1);
        check("w9 fill dout", 32'(dout), 32'h99);
        expect_hit("w5 hit", 18'h0000B, 8'h55);

        // Flush while in REQ
        do_reset();
        fetch("fl w1", 18'h00002, 16'h1111, 22'h1_0001, 8'h11);
        fetch("fl w2", 18'h00004, 16'h2222, 22'h1_0002, 8'h22);
        addr = 18'h00006; cs = 1'b1;
        wait_req(seen, sa);
        check("fl w3 req", 32'(seen), 32'd1);
        downloading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush req low", 32'(sdram_req), 32'd0);
            check("flush ok low", 32'(data_ok), 32'd0);
        end
        downloading = 1'b0;
        fetch("post flush w1", 18'h00002, 16'h1111, 22'h1_0001, 8'h11);

        // Asynchronous reset mid-WAIT
        addr = 18'h00008; cs = 1'b1;
        wait_req(seen, sa);
        check("ar req", 32'(seen), 32'd1);
        sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("ar dout", 32'(dout), 32'd0);
        check("ar ok", 32'(data_ok), 32'd0);
        check("ar req low", 32'(sdram_req), 32'd0);
        check("ar sdram_addr", 32'(sdram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1; cs = 1'b0;
        data_rdy = 1'b1; data_read = 16'h4444; @(negedge clk); data_rdy = 1'b0;
        check("stray rdy ok", 32'(data_ok), 32'd0);
        check("stray rdy req", 32'(sdram_req), 32'd0);
        fetch("ar refetch w4", 18'h00008, 16'h4444, 22'h1_0004, 8'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
